// File: rtl/switch_proc_gen.sv
// Switch front-end: synchronise, debounce, add a constant, then show the
// result on LEDs as pass-through, blink, rotate or off.
module switch_proc_gen #(
   parameter int WIDTH     = 4,
   parameter int ADD_K     = 1,
   parameter int DIV_N     = 25000000,
   parameter int DB_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] led,
   output logic             tick
);

   localparam int DIV_W = $clog2(DIV_N);
   localparam int CNT_W = $clog2(DB_CYCLES + 1);

   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV_N - 1);
   localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DB_CYCLES - 1);

   localparam logic [1:0] M_PASS  = 2'b00;
   localparam logic [1:0] M_BLINK = 2'b01;
   localparam logic [1:0] M_ROT   = 2'b10;
   localparam logic [1:0] M_OFF   = 2'b11;

   logic [WIDTH-1:0] meta;
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] deb;
   logic [CNT_W-1:0] cnt [WIDTH];
   logic [DIV_W-1:0] div;
   logic             phase;
   logic [WIDTH-1:0] rot;
   logic             in_rot;
   logic [WIDTH-1:0] val;
   logic [WIDTH-1:0] rot_l;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= sw;
         sync <= meta;
      end
   end

   // Each bit needs DB_CYCLES consecutive disagreeing samples to flip.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         deb <= '0;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DB_MAX) begin
               deb[i] <= sync[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div   <= '0;
         phase <= 1'b0;
         tick  <= 1'b0;
      end else if (div == DIV_MAX) begin
         div   <= '0;
         phase <= ~phase;
         tick  <= 1'b1;
      end else begin
         div   <= div + 1'b1;
         tick  <= 1'b0;
      end
   end

   assign val = deb + WIDTH'(ADD_K);

   // For WIDTH==1 both shifts collapse onto the same bit, leaving rot as-is.
   assign rot_l = (rot << 1) | (rot >> (WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rot    <= '0;
         in_rot <= 1'b0;
         led    <= '0;
      end else begin
         in_rot <= (mode == M_ROT);
         if (mode == M_ROT) begin
            if (!in_rot) rot <= val;
            else if (tick) rot <= rot_l;
         end
         case (mode)
            M_PASS:  led <= val;
            M_BLINK: led <= phase ? val : '0;
            M_ROT:   led <= rot;
            M_OFF:   led <= '0;
            default: led <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_switch_proc_gen.sv
// Bench for switch_proc_gen: directed scenarios plus random switch/mode
// traffic, all checked against a cycle-indexed reference model.
module tb_switch_proc_gen;

   localparam int W  = 4;
   localparam int K  = 1;
   localparam int DN = 4;
   localparam int DB = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] sw;
   logic [1:0]   mode;
   logic [W-1:0] led;
   logic         tick;

   switch_proc_gen #(
      .WIDTH(W), .ADD_K(K), .DIV_N(DN), .DB_CYCLES(DB)
   ) dut (
      .clk(clk), .rst(rst), .sw(sw), .mode(mode),
      .led(led), .tick(tick)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   // Model state: e = edges since reset release.
   int           e;
   logic [W-1:0] m_deb;
   logic [W-1:0] m_rot;
   logic [W-1:0] m_led;
   bit           m_in_rot;
   // hist[j] = synchronised value presented to the debouncer at edge j+1
   logic [W-1:0] hist [$];

   function automatic void model_reset();
      e        = 0;
      m_deb    = '0;
      m_rot    = '0;
      m_led    = '0;
      m_in_rot = 0;
      hist     = {};
      hist.push_back('0);
      hist.push_back('0);
   endfunction

   function automatic void model_step(input logic [W-1:0] s,
                                      input logic [1:0] m);
      logic [W-1:0] val;
      bit           ph;
      bit           tk;
      bit           flip;
      val = m_deb + W'(K);
      ph  = ((e / DN) % 2) == 1;
      tk  = (e > 0) && (e % DN == 0);
      case (m)
         2'd0: m_led = val;
         2'd1: m_led = ph ? val : '0;
         2'd2: m_led = m_rot;
         default: m_led = '0;
      endcase
      if (m == 2'd2) begin
         if (!m_in_rot) m_rot = val;
         else if (tk) m_rot = {m_rot[W-2:0], m_rot[W-1]};
      end
      m_in_rot = (m == 2'd2);
      // a bit flips once the last DB samples all disagree with it
      if (e + 1 >= DB) begin
         for (int b = 0; b < W; b++) begin
            flip = 1;
            for (int j = e + 1 - DB; j <= e; j++)
               if (hist[j][b] == m_deb[b]) flip = 0;
            if (flip) m_deb[b] = ~m_deb[b];
         end
      end
      hist.push_back(s);
      e++;
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_step(sw, mode);
      #1;
      check("led", 32'(led), 32'(m_led));
      check("tick", 32'(tick), 32'((e % DN) == 0));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      check("rst_led_async", 32'(led), 32'h0);
      check("rst_tick_async", 32'(tick), 32'h0);
      @(negedge clk);
      @(negedge clk);
      check("rst_led_hold", 32'(led), 32'h0);
      check("rst_tick_hold", 32'(tick), 32'h0);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      rst  = 1'b1;
      sw   = 4'hF;
      mode = 2'b00;
      model_reset();
      do_reset();
      run(10);

      sw = 4'h0;
      run(8);
      sw = 4'h4;
      run(10);

      sw = 4'h5;
      run(2);
      sw = 4'h4;
      run(8);
      sw = 4'h5;
      run(8);
      sw = 4'h4;
      run(8);

      mode = 2'b01;
      run(20);

      mode = 2'b00;
      sw   = 4'h0;
      run(8);
      mode = 2'b10;
      run(20);
      sw = 4'hA;
      run(12);

      do_reset();
      run(6);
      sw   = 4'hF;
      mode = 2'b00;
      run(10);
      mode = 2'b11;
      run(4);

      for (int it = 0; it < 400; it++) begin
         if ($urandom_range(0, 2) == 0) sw = W'($urandom);
         if ($urandom_range(0, 5) == 0) mode = 2'($urandom);
         if ($urandom_range(0, 59) == 0) do_reset();
         run($urandom_range(1, 6));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/switch_proc_gen.md
SWITCH_PROC_GEN -- requirements
Module: switch_proc_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of switch/LED channels (>=1).
REQ-002 SHALL have parameter ADD_K, default 1, constant added to debounced switch value.
REQ-003 SHALL have parameter DIV_N, default 25000000, clk cycles per blink phase (>=2).
REQ-004 SHALL have parameter DB_CYCLES, default 16, debounce stability length in cycles (>=1).
REQ-005 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port sw  input  WIDTH  raw asynchronous switch inputs.
REQ-008 SHALL have port mode  input  2  00 pass, 01 blink, 10 rotate, 11 off.
REQ-009 SHALL have port led  output  WIDTH  registered LED drive.
REQ-010 SHALL have port tick  output  1  one-cycle pulse at each blink phase toggle.

Function
REQ-011 SHALL pass each sw bit through a 2-flop synchroniser (sync); no other logic on sw before it.
REQ-012 SHALL keep a per-bit debounced value deb and a per-bit counter; counter clears on any edge where sync==deb.
REQ-013 SHALL update deb bit to sync bit on the DB_CYCLES-th consecutive edge with sync!=deb, clearing that counter.
REQ-014 SHALL form val = (deb + ADD_K) mod 2^WIDTH; carry out discarded.
REQ-015 SHALL run a divider counter 0..DIV_N-1; at DIV_N-1 it wraps to 0, phase toggles, and tick is 1 for that following cycle only.
REQ-016 SHALL run the divider free in all modes.
REQ-017 mode 00: led <= val each cycle.
REQ-018 mode 01: led <= val when phase==1, else 0.
REQ-019 mode 10: rotate register rot loads val on the first cycle mode==10 after any other mode or reset; thereafter rot rotates left by one bit on each cycle tick is asserted; led <= rot.
REQ-020 mode 10, WIDTH==1: rotation leaves rot unchanged.
REQ-021 mode 11: led <= 0.
REQ-022 SHALL sample mode directly, with no synchroniser; a mode change affects led on the next edge.
REQ-023 SHALL not reload rot on val changes while mode stays 10.
REQ-024 Latency sw->led in mode 00 SHALL be 2+DB_CYCLES+1 edges for a clean, stable change.
REQ-025 SHALL reject bounces shorter than DB_CYCLES cycles; deb is unchanged.
REQ-026 SHALL give each bit its own debouncer, so bits settle independently.

Reset
REQ-027 On rst=1 SHALL immediately clear sync, deb, debounce counters, divider, phase, rot, led and tick to 0, independent of clk.
REQ-028 After rst deassert SHALL treat the first mode==10 cycle as mode entry (reload rot).
REQ-029 rst asserted mid-operation SHALL abort debounce and rotation with no residual state.

Verification (WIDTH=4, ADD_K=1, DIV_N=4, DB_CYCLES=3)
REQ-030 Assert rst with sw=F, mode=00 -> led=0, tick=0 throughout; after release led=1 until debounce completes.
REQ-031 mode=00, sw 0->4 held -> led=5 exactly 6 edges after sw change, steady thereafter.
REQ-032 deb=4 (led=5), sw bit0 pulses 1 for 2 cycles -> led stays 5; same pulse held 3+ synced cycles -> led=6.
REQ-033 mode=01, deb=4 -> led alternates 5 for 4 cycles and 0 for 4 cycles; tick pulses every 4 cycles.
REQ-034 deb=0, mode 00->10 -> rot=1, then led 2,4,8,1 on successive ticks; sw changes during rotation ignored.
REQ-035 sw=F, mode=00 -> led=0 (wrap); assert rst mid-rotation -> led=0 within the same cycle.
